axi4l_regbank: RTL and testbench

AXI4L_REGBANK -- requirements
Module: axi4l_regbank

---
 rtl/axi4l_pkg.sv | 41 ++++
 rtl/axi4l_wr_join.sv | 79 +++++++
 rtl/axi4l_regbank.sv | 158 +++++++++++++++
 tb/tb_axi4l_regbank.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, register-map layout, write-join states.
// The map is ctrl block, then stat block, then the IE/IS pair; decode_reg classifies a word index.
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_BASE = 0;
  localparam int IE_OFS    = 0;  // offsets of IE/IS past the end of the stat block
  localparam int IS_OFS    = 1;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_BOTH,
    WR_RESP
  } wr_state_t;

  typedef enum logic [2:0] {
    RK_CTRL,
    RK_STAT,
    RK_IE,
    RK_IS,
    RK_NONE
  } reg_kind_t;

  function automatic reg_kind_t decode_reg(input int idx, input int nrw, input int nro,
                                           input bit irq_en);
    if (idx >= CTRL_BASE && idx < CTRL_BASE + nrw) return RK_CTRL;
    if (idx >= CTRL_BASE + nrw && idx < CTRL_BASE + nrw + nro) return RK_STAT;
    if (irq_en && idx == CTRL_BASE + nrw + nro + IE_OFS) return RK_IE;
    if (irq_en && idx == CTRL_BASE + nrw + nro + IS_OFS) return RK_IS;
    return RK_NONE;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axi4l_wr_join.sv
// Joins AW and W beats arriving in either order; commits one cycle after both are held, with bvalid.
// While a beat is held or B is pending that channel's ready is low; B holds until bready.
module axi4l_wr_join
  import axi4l_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] awaddr,
  input  logic          awvalid,
  output logic          awready,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          wvalid,
  output logic          wready,
  output logic [1:0]    bresp,
  output logic          bvalid,
  input  logic          bready,
  input  logic          wr_err,
  output logic          commit,
  output logic [AW-1:0] cmt_addr,
  output logic [31:0]   cmt_data,
  output logic [3:0]    cmt_strb
);

  wr_state_t state;
  logic      aw_hs, w_hs, got_aw, got_w;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign got_aw = aw_hs | (state == WR_HAVE_AW);
  assign got_w  = w_hs | (state == WR_HAVE_W);
  assign commit = (state == WR_BOTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WR_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (state)
        WR_BOTH: begin
          state  <= WR_RESP;
          bvalid <= 1'b1;
          bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end
        WR_RESP: begin
          if (bready) begin
            state   <= WR_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: begin
          awready <= ~got_aw;
          wready  <= ~got_w;
          if (got_aw && got_w) state <= WR_BOTH;
          else if (got_aw)     state <= WR_HAVE_AW;
          else if (got_w)      state <= WR_HAVE_W;
          else                 state <= WR_IDLE;
        end
      endcase
    end
  end

  // Payload registers need no reset: they are only consumed once the FSM says they are held.
  always_ff @(posedge clk) begin
    if (aw_hs) cmt_addr <= awaddr;
    if (w_hs) begin
      cmt_data <= wdata;
      cmt_strb <= wstrb;
    end
  end

endmodule

// File: rtl/axi4l_regbank.sv
// AXI4-Lite register bank: NRW control, NRO status, optional IE/IS pair (AXI4L_REGBANK_IRQ_EN).
// B one cycle after AW+W held, stalls until bready; R one cycle after AR, arready low while R pending.
module axi4l_regbank
  import axi4l_pkg::*;
#(
  parameter  int NRW  = 4,
  parameter  int NRO  = 4,
  parameter  int NIRQ = 8,
  localparam int NREG = NRW + NRO + 2,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAW+1:0]    s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [RAW+1:0]    s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [NRW*32-1:0] ctrl_o,
  output logic [NRW-1:0]    ctrl_wr_o,
  input  logic [NRO*32-1:0] stat_i,
  input  logic [NIRQ-1:0]   irq_evt_i,
  output logic              intr
);

`ifdef AXI4L_REGBANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic           commit, wr_err;
  logic [RAW+1:0] cmt_addr;
  logic [31:0]    cmt_data, wmask, rd_val;
  logic [3:0]     cmt_strb;
  logic [RAW-1:0] wa, ra;
  reg_kind_t      wk, rk;
  logic [31:0]    ctrl_q [NRW];
  logic           unused_ok;

  assign wa     = cmt_addr[RAW+1:2];
  assign ra     = s_axi_araddr[RAW+1:2];
  assign wk     = decode_reg(int'(wa), NRW, NRO, IRQ_EN);
  assign rk     = decode_reg(int'(ra), NRW, NRO, IRQ_EN);
  assign wmask  = strb_mask(cmt_strb);
  assign wr_err = (wk == RK_STAT) || (wk == RK_NONE);

  axi4l_wr_join #(.AW(RAW + 2)) u_wr_join (
    .clk      (clk),
    .rst      (rst),
    .awaddr   (s_axi_awaddr),
    .awvalid  (s_axi_awvalid),
    .awready  (s_axi_awready),
    .wdata    (s_axi_wdata),
    .wstrb    (s_axi_wstrb),
    .wvalid   (s_axi_wvalid),
    .wready   (s_axi_wready),
    .bresp    (s_axi_bresp),
    .bvalid   (s_axi_bvalid),
    .bready   (s_axi_bready),
    .wr_err   (wr_err),
    .commit   (commit),
    .cmt_addr (cmt_addr),
    .cmt_data (cmt_data),
    .cmt_strb (cmt_strb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NRW; k++) ctrl_q[k] <= '0;
      ctrl_wr_o <= '0;
    end else begin
      for (int k = 0; k < NRW; k++) begin
        ctrl_wr_o[k] <= commit && (wk == RK_CTRL) && (int'(wa) == k);
        if (commit && (wk == RK_CTRL) && (int'(wa) == k))
          ctrl_q[k] <= (ctrl_q[k] & ~wmask) | (cmt_data & wmask);
      end
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int k = 0; k < NRW; k++) ctrl_o[k*32 +: 32] = ctrl_q[k];
  end

`ifdef AXI4L_REGBANK_IRQ_EN
  logic [NIRQ-1:0] ie_q, is_q, wmask_i, wdata_i;

  assign wmask_i = wmask[NIRQ-1:0];
  assign wdata_i = cmt_data[NIRQ-1:0];

  // A new event wins over a W1C clear landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q <= '0;
      is_q <= '0;
    end else begin
      if (commit && wk == RK_IE)
        ie_q <= (ie_q & ~wmask_i) | (wdata_i & wmask_i);
      if (commit && wk == RK_IS)
        is_q <= (is_q & ~(wdata_i & wmask_i)) | irq_evt_i;
      else
        is_q <= is_q | irq_evt_i;
    end
  end

  assign intr      = |(ie_q & is_q);
  assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot, cmt_addr[1:0], s_axi_araddr[1:0]};
`else
  assign intr      = 1'b0;
  assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot, cmt_addr[1:0], s_axi_araddr[1:0],
                       irq_evt_i};
`endif

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NRW; k++)
      if (int'(ra) == k) rd_val = ctrl_q[k];
    for (int k = 0; k < NRO; k++)
      if (int'(ra) == NRW + k) rd_val = stat_i[k*32 +: 32];
`ifdef AXI4L_REGBANK_IRQ_EN
    if (rk == RK_IE) rd_val = 32'(ie_q);
    if (rk == RK_IS) rd_val = 32'(is_q);
`endif
  end

  // Read samples the registers before any commit on the same edge, so it sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && !s_axi_rvalid) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_val;
      s_axi_rresp  <= (rk == RK_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  assign s_axi_arready = ~s_axi_rvalid;

endmodule

// File: tb/tb_axi4l_regbank.sv
// Scoreboard bench for axi4l_regbank: expected B/R responses queued at stimulus, checked on handshake.
module tb_axi4l_regbank;
  localparam int NRW = 4, NRO = 4, NIRQ = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [5:0]        s_axi_awaddr, s_axi_araddr;
  logic [2:0]        s_axi_awprot, s_axi_arprot;
  logic              s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]       s_axi_wdata, s_axi_rdata;
  logic [3:0]        s_axi_wstrb;
  logic [1:0]        s_axi_bresp, s_axi_rresp;
  logic              s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic              s_axi_rvalid, s_axi_rready;
  logic [NRW*32-1:0] ctrl_o;
  logic [NRW-1:0]    ctrl_wr_o;
  logic [NRO*32-1:0] stat_i;
  logic [NIRQ-1:0]   irq_evt_i;
  logic              intr;

  int          n_cmp = 0, n_err = 0;
  logic [1:0]  exp_b[$];
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_rr[$];
  logic [31:0] ctrl_m [NRW];
  int          wr_pulses [NRW];

  axi4l_regbank #(.NRW(NRW), .NRO(NRO), .NIRQ(NIRQ)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o), .stat_i(stat_i),
    .irq_evt_i(irq_evt_i), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NRW; k++)
        if (ctrl_wr_o[k]) begin
          wr_pulses[k]++;
          chk("wr_pulse_with_bvalid", 32'(s_axi_bvalid), 32'd1);
        end
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 32'(s_axi_bresp), 32'hFFFF_FFFF);
        else                   chk("bresp", 32'(s_axi_bresp), 32'(exp_b.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_rd.size() == 0) chk("r_unexpected", s_axi_rdata, 32'hFFFF_FFFF);
        else begin
          chk("rdata", s_axi_rdata, exp_rd.pop_front());
          chk("rresp", 32'(s_axi_rresp), 32'(exp_rr.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [5:0] a);
    bit done = 1'b0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); done = s_axi_awready;
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0;
    if (!done) chk("aw_timeout", 32'(s_axi_awready), 32'd1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    bit done = 1'b0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); done = s_axi_wready;
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    if (!done) chk("w_timeout", 32'(s_axi_wready), 32'd1);
  endtask

  task automatic ar_send(input logic [5:0] a);
    bit done = 1'b0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); done = s_axi_arready;
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
    if (!done) chk("ar_timeout", 32'(s_axi_arready), 32'd1);
  endtask

  task automatic wait_b();
    for (int i = 0; i < 100 && exp_b.size() != 0; i++) tick();
    if (exp_b.size() != 0) begin
      chk("b_timeout", 32'(exp_b.size()), 32'd0);
      exp_b.delete();
    end
  endtask

  task automatic wait_r();
    for (int i = 0; i < 100 && exp_rd.size() != 0; i++) tick();
    if (exp_rd.size() != 0) begin
      chk("r_timeout", 32'(exp_rd.size()), 32'd0);
      exp_rd.delete(); exp_rr.delete();
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] rsp);
    exp_b.push_back(rsp);
    fork
      aw_send(a);
      w_send(d, s);
    join
    wait_b();
  endtask

  // Write to ctrl/stat/unmapped space, keeping the ctrl model in step.
  task automatic wr_m(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[5:2]);
    if (idx < NRW) begin
      ctrl_m[idx] = merge(ctrl_m[idx], d, s);
      wr(a, d, s, 2'b00);
    end else begin
      wr(a, d, s, 2'b10);
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] d, input logic [1:0] rsp);
    exp_rd.push_back(d); exp_rr.push_back(rsp);
    ar_send(a);
    wait_r();
  endtask

  task automatic chk_ctrl(input string tag);
    for (int k = 0; k < NRW; k++)
      chk($sformatf("%s_ctrl%0d", tag, k), ctrl_o[k*32 +: 32], ctrl_m[k]);
  endtask

  task automatic chk_intr(input string tag, input logic e);
    @(negedge clk); chk(tag, 32'(intr), 32'(e));
    @(posedge clk); #1;
  endtask

  task automatic pulse_irq(input logic [NIRQ-1:0] v);
    irq_evt_i = v; tick(); irq_evt_i = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    stat_i = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'hDEAD_BEEF};
    irq_evt_i = '0;
    for (int k = 0; k < NRW; k++) begin ctrl_m[k] = '0; wr_pulses[k] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_awready", 32'(s_axi_awready), 32'd1);
    chk("rst_wready", 32'(s_axi_wready), 32'd1);
    chk("rst_arready", 32'(s_axi_arready), 32'd1);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    chk_ctrl("rst");
    @(posedge clk); #1;

    // W leads AW by three cycles, partial strobe
    exp_b.push_back(2'b00);
    w_send(32'hA5A5_1234, 4'b0011);
    repeat (2) tick();
    aw_send(6'h04);
    wait_b();
    ctrl_m[1] = merge(ctrl_m[1], 32'hA5A5_1234, 4'b0011);
    chk("wfirst_ctrl1", ctrl_o[63:32], 32'h0000_1234);
    chk("wfirst_pulse1", 32'(wr_pulses[1]), 32'd1);
    chk("wfirst_pulse0", 32'(wr_pulses[0]), 32'd0);

    // byte strobes on ctrl
    wr_m(6'h00, 32'hFFFF_FFFF, 4'hF);
    wr_m(6'h00, 32'h1234_5678, 4'b0100);
    wr_m(6'h0C, 32'hCAFE_F00D, 4'b1001);
    chk("strb_ctrl0", ctrl_o[31:0], 32'hFF34_FFFF);
    chk("strb_ctrl3", ctrl_o[127:96], 32'hCA00_000D);
    chk_ctrl("strb");
    for (int k = 0; k < NRW; k++) rd(6'(k * 4), ctrl_m[k], 2'b00);

    // status writes are rejected, reads return the live input
    wr_m(6'h10, 32'h0BAD_0BAD, 4'hF);
    chk_ctrl("stat_wr");
    rd(6'h10, 32'hDEAD_BEEF, 2'b00);
    rd(6'h1C, 32'h4444_0003, 2'b00);

    // B stalled by bready low; a second AW must wait for the B handshake
    s_axi_bready = 1'b0;
    exp_b.push_back(2'b00);
    fork
      aw_send(6'h08);
      w_send(32'h1111_2222, 4'hF);
    join
    ctrl_m[2] = 32'h1111_2222;
    for (int i = 0; i < 10 && !s_axi_bvalid; i++) tick();
    s_axi_awaddr = 6'h0C; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bstall_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("bstall_awready", 32'(s_axi_awready), 32'd0);
      chk("bstall_wready", 32'(s_axi_wready), 32'd0);
      @(posedge clk); #1;
    end
    chk("bstall_ctrl2", ctrl_o[95:64], 32'h1111_2222);
    s_axi_bready = 1'b1;
    exp_b.push_back(2'b00);
    fork
      aw_send(6'h0C);
      w_send(32'h0000_0055, 4'b0001);
    join
    wait_b();
    ctrl_m[3] = merge(ctrl_m[3], 32'h0000_0055, 4'b0001);
    chk_ctrl("bstall");

    // read lands on the same edge as a write commit: old value returned
    exp_rd.push_back(ctrl_m[0]); exp_rr.push_back(2'b00);
    exp_b.push_back(2'b00);
    fork
      aw_send(6'h00);
      w_send(32'h0000_0BEE, 4'hF);
    join
    ar_send(6'h00);
    ctrl_m[0] = 32'h0000_0BEE;
    wait_b();
    wait_r();
    rd(6'h00, 32'h0000_0BEE, 2'b00);

`ifdef AXI4L_REGBANK_IRQ_EN
    wr(6'h20, 32'h0000_0001, 4'hF, 2'b00);
    rd(6'h20, 32'h0000_0001, 2'b00);
    pulse_irq(8'h01);
    chk_intr("irq_set_intr", 1'b1);
    exp_b.push_back(2'b00);
    fork
      aw_send(6'h24);
      w_send(32'h0000_0001, 4'hF);
    join
    pulse_irq(8'h01);  // coincides with the W1C commit edge
    wait_b();
    chk_intr("irq_race_intr", 1'b1);
    rd(6'h24, 32'h0000_0001, 2'b00);
    wr(6'h24, 32'h0000_0001, 4'hF, 2'b00);
    chk_intr("irq_clr_intr", 1'b0);
    rd(6'h24, 32'h0000_0000, 2'b00);
    pulse_irq(8'h08);
    chk_intr("irq_masked_intr", 1'b0);
    rd(6'h24, 32'h0000_0008, 2'b00);
    wr(6'h24, 32'h0000_0008, 4'h0, 2'b00);
    rd(6'h24, 32'h0000_0008, 2'b00);
    wr(6'h24, 32'h0000_0008, 4'h1, 2'b00);
    rd(6'h24, 32'h0000_0000, 2'b00);
`else
    wr(6'h20, 32'h0000_0001, 4'hF, 2'b10);
    rd(6'h20, 32'h0000_0000, 2'b10);
    rd(6'h24, 32'h0000_0000, 2'b10);
    pulse_irq(8'hFF);
    chk_intr("noirq_intr", 1'b0);
`endif

    // unmapped read held by rready low
    s_axi_rready = 1'b0;
    exp_rd.push_back(32'h0); exp_rr.push_back(2'b10);
    ar_send(6'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstall_rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("rstall_rdata", s_axi_rdata, 32'd0);
      chk("rstall_rresp", 32'(s_axi_rresp), 32'd2);
      chk("rstall_arready", 32'(s_axi_arready), 32'd0);
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b1;
    wait_r();

    // reset between AW and W: transaction dropped
    aw_send(6'h04);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < NRW; k++) ctrl_m[k] = '0;
    @(negedge clk);
    chk("rstmid_awready", 32'(s_axi_awready), 32'd1);
    chk("rstmid_wready", 32'(s_axi_wready), 32'd1);
    chk("rstmid_arready", 32'(s_axi_arready), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid_no_b", 32'(s_axi_bvalid), 32'd0);
      @(posedge clk); #1;
    end
    chk_ctrl("rstmid");

    chk("end_b_queue", 32'(exp_b.size()), 32'd0);
    chk("end_r_queue", 32'(exp_rd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
